// File: rtl/channel_4_noise_voice_pkg.sv
// Shared constants and helpers for the channel-4 noise voice.
package channel_4_pkg;

  localparam int LFSR_W      = 15;
  localparam int ACC_W       = 32;
  localparam int ENV_W       = 9;
  localparam int SAMPLE_W    = 10;
  localparam int LONG_TAP_C  = 1;
  localparam int SHORT_TAP_C = 6;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h0001;

  typedef enum logic {
    MODE_LONG  = 1'b0,
    MODE_SHORT = 1'b1
  } lfsr_mode_e;

  // Zero-extend the envelope and optionally negate it (two's complement).
  // An envelope of zero yields zero in both polarities.
  function automatic logic [SAMPLE_W-1:0] signed_env(
    input logic [ENV_W-1:0] env,
    input logic             neg
  );
    logic [SAMPLE_W-1:0] ext;
    ext = {1'b0, env};
    if (neg) begin
      signed_env = 10'd0 - ext;
    end else begin
      signed_env = ext;
    end
  endfunction

endpackage

// File: rtl/channel_4_noise_voice_if.sv
// Sequencer-to-noise-voice link: strobe, phase delta, envelope, mode in;
// sample, sample valid and LFSR state out.
interface channel_4_noise_voice_if;
  import channel_4_pkg::*;

  logic                  i_sample_stb;
  logic [ACC_W-1:0]      i_phase_delta;
  logic [ENV_W-1:0]      i_envelope;
  logic                  i_short_mode;
  logic [SAMPLE_W-1:0]   o_sample;
  logic                  o_sample_valid;
  logic [LFSR_W-1:0]     o_lfsr;

  modport master (
    output i_sample_stb, i_phase_delta, i_envelope, i_short_mode,
    input  o_sample, o_sample_valid, o_lfsr
  );

  modport slave (
    input  i_sample_stb, i_phase_delta, i_envelope, i_short_mode,
    output o_sample, o_sample_valid, o_lfsr
  );

endinterface

// File: rtl/channel_4_noise_voice_lfsr.sv
// 15-bit NES-style noise LFSR: shifts right, feedback = bit0 ^ bit[tap],
// tap selected per step by the long/short mode.
module noise_lfsr
  import channel_4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int                LONG_TAP  = LONG_TAP_C,
  parameter int                SHORT_TAP = SHORT_TAP_C
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  lfsr_mode_e        i_mode,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;
  logic [LFSR_W-1:0] w_next;

  // Feedback bit and next state; holds when no step is requested.
  always_comb begin
    w_fb   = 1'b0;
    w_next = r_state;
    case (i_mode)
      MODE_SHORT: w_fb = r_state[0] ^ r_state[SHORT_TAP];
      MODE_LONG:  w_fb = r_state[0] ^ r_state[LONG_TAP];
      default:    w_fb = r_state[0] ^ r_state[LONG_TAP];
    endcase
    if (i_step) begin
      w_next = {w_fb, r_state[LFSR_W-1:1]};
    end else begin
      w_next = r_state;
    end
  end

  // State register, loaded with the seed on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SEED;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/channel_4_noise_voice.sv
// Channel-4 noise voice: phase accumulator carries clock the noise LFSR,
// whose low bit picks +envelope or -envelope for each sample strobe.
// The output register samples the post-step LFSR bit directly (the new
// bit0 is old bit1 when stepping), so the sample lands two cycles after
// the strobe, alongside the updated LFSR state.
module channel_4_noise_voice
  import channel_4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int                LONG_TAP  = LONG_TAP_C,
  parameter int                SHORT_TAP = SHORT_TAP_C
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  channel_4_noise_voice_if.slave  io_bus
);

  logic [ACC_W-1:0]    r_acc;
  logic                r_s0_valid;
  logic                r_s0_carry;
  logic [ENV_W-1:0]    r_s0_env;
  lfsr_mode_e          r_s0_mode;
  logic                r_s0_zero;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_sample_valid;

  logic [ACC_W:0]      w_sum;
  logic                w_step;
  logic                w_new_bit0;
  logic [LFSR_W-1:0]   w_lfsr;
  logic [SAMPLE_W-1:0] w_sample_next;

  assign w_sum  = {1'b0, r_acc} + {1'b0, io_bus.i_phase_delta};
  assign w_step = r_s0_valid & r_s0_carry;

  // Stage 0: advance the accumulator and capture this strobe's inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc      <= 32'h0000_0000;
      r_s0_valid <= 1'b0;
      r_s0_carry <= 1'b0;
      r_s0_env   <= 9'd0;
      r_s0_mode  <= MODE_LONG;
      r_s0_zero  <= 1'b0;
    end else begin
      r_s0_valid <= io_bus.i_sample_stb;
      if (io_bus.i_sample_stb) begin
        r_acc      <= w_sum[ACC_W-1:0];
        r_s0_carry <= w_sum[ACC_W];
        r_s0_env   <= io_bus.i_envelope;
        r_s0_mode  <= lfsr_mode_e'(io_bus.i_short_mode);
        r_s0_zero  <= (io_bus.i_phase_delta == 32'h0000_0000);
      end
    end
  end

  noise_lfsr #(
    .SEED      (SEED),
    .LONG_TAP  (LONG_TAP),
    .SHORT_TAP (SHORT_TAP)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_step  (w_step),
    .i_mode  (r_s0_mode),
    .o_state (w_lfsr)
  );

  // Sign/gate: silence on zero delta, else the post-step LFSR bit picks the sign.
  always_comb begin
    w_new_bit0    = w_lfsr[0];
    w_sample_next = 10'd0;
    if (w_step) begin
      w_new_bit0 = w_lfsr[1];
    end else begin
      w_new_bit0 = w_lfsr[0];
    end
    if (r_s0_zero) begin
      w_sample_next = 10'd0;
    end else begin
      w_sample_next = signed_env(r_s0_env, w_new_bit0);
    end
  end

  // Output register: sample updates only on a valid pipeline slot, else holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample       <= 10'd0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_sample <= w_sample_next;
      end
    end
  end

  assign io_bus.o_sample       = r_sample;
  assign io_bus.o_sample_valid = r_sample_valid;
  assign io_bus.o_lfsr         = w_lfsr;

endmodule

// File: tb/tb_channel_4_noise_voice.sv
// Directed self-checking bench for the channel-4 noise voice.
module tb_channel_4_noise_voice;
  import channel_4_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  channel_4_noise_voice_if u_bus();

  channel_4_noise_voice u_dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .io_bus (u_bus)
  );

  int r_total = 0;
  int r_bad   = 0;
  int r_cyc   = 0;

  logic [9:0]  q_samp[$];
  logic [14:0] q_lfsr[$];
  int          q_vcyc[$];
  int          q_scyc[$];

  // Cycle counter for latency measurement.
  always @(posedge i_clk) r_cyc <= r_cyc + 1;

  // Capture every valid sample away from the active edge.
  always @(negedge i_clk) begin
    if (u_bus.o_sample_valid === 1'b1) begin
      q_samp.push_back(u_bus.o_sample);
      q_lfsr.push_back(u_bus.o_lfsr);
      q_vcyc.push_back(r_cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    r_total++;
    if (act !== exp) begin
      r_bad++;
      $display("FAIL %s: got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic [14:0] model_step(input logic [14:0] s, input logic m);
    logic fb;
    fb = s[0] ^ (m ? s[6] : s[1]);
    return {fb, s[14:1]};
  endfunction

  task automatic clear_q();
    q_samp.delete(); q_lfsr.delete(); q_vcyc.delete(); q_scyc.delete();
  endtask

  task automatic drive(input logic [31:0] d, input logic [8:0] e, input logic m);
    @(posedge i_clk); #1;
    u_bus.i_sample_stb  = 1'b1;
    u_bus.i_phase_delta = d;
    u_bus.i_envelope    = e;
    u_bus.i_short_mode  = m;
    q_scyc.push_back(r_cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      u_bus.i_sample_stb = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    clear_q();
  endtask

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    int zero_seen;
    int first_ret;
    logic [14:0] m;
    logic [9:0]  es;

    u_bus.i_sample_stb  = 1'b0;
    u_bus.i_phase_delta = 32'h0000_0000;
    u_bus.i_envelope    = 9'd0;
    u_bus.i_short_mode  = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    #2;

    // Test 1: reset values, async mid-cycle reset, in-flight strobe dropped.
    chk("t1_rst_sample", 32'(u_bus.o_sample), 32'h0);
    chk("t1_rst_valid",  32'(u_bus.o_sample_valid), 32'h0);
    chk("t1_rst_lfsr",   32'(u_bus.o_lfsr), 32'h0001);
    drive(32'h8000_0000, 9'd100, 1'b0);
    drive(32'h8000_0000, 9'd100, 1'b0);
    idle(3);
    chk("t1_pre_lfsr",   32'(u_bus.o_lfsr), 32'h4000);
    chk("t1_pre_sample", 32'(u_bus.o_sample), 32'h064);
    clear_q();
    drive(32'h8000_0000, 9'd100, 1'b0);
    idle(1);
    #2 i_rst = 1'b1;
    #1;
    chk("t1_async_lfsr",   32'(u_bus.o_lfsr), 32'h0001);
    chk("t1_async_sample", 32'(u_bus.o_sample), 32'h0);
    chk("t1_async_valid",  32'(u_bus.o_sample_valid), 32'h0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    idle(4);
    chk("t1_no_valid", 32'(q_vcyc.size()), 32'd0);
    clear_q();

    // Test 2: half-scale delta, carry every second strobe.
    drive(32'h8000_0000, 9'd20, 1'b0);
    idle(3);
    drive(32'h8000_0000, 9'd20, 1'b0);
    idle(4);
    chk("t2_count", 32'(q_vcyc.size()), 32'd2);
    if (q_vcyc.size() == 2) begin
      chk("t2_s0", 32'(q_samp[0]), 32'h3EC);
      chk("t2_l0", 32'(q_lfsr[0]), 32'h0001);
      chk("t2_s1", 32'(q_samp[1]), 32'h014);
      chk("t2_l1", 32'(q_lfsr[1]), 32'h4000);
      chk("t2_lat0", 32'(q_vcyc[0] - q_scyc[0]), 32'd2);
      chk("t2_lat1", 32'(q_vcyc[1] - q_scyc[1]), 32'd2);
    end
    chk("t2_hold", 32'(u_bus.o_sample), 32'h014);

    // Test 3: max delta back-to-back, long then short mode.
    for (int md = 0; md < 2; md++) begin
      do_reset();
      repeat (11) drive(32'hFFFF_FFFF, 9'd50, md[0]);
      idle(4);
      chk(md == 0 ? "t3_long_lfsr" : "t3_short_lfsr", 32'(u_bus.o_lfsr),
          md == 0 ? 32'h0020 : 32'h4020);
      chk("t3_count", 32'(q_vcyc.size()), 32'd11);
      errs = 0;
      for (int k = 0; k < q_vcyc.size() && k < q_scyc.size(); k++)
        if (q_vcyc[k] - q_scyc[k] != 2) errs++;
      chk("t3_latency", 32'(errs), 32'd0);
      if (q_vcyc.size() == 11) chk("t3_back_to_back", 32'(q_vcyc[10] - q_vcyc[0]), 32'd10);
    end

    // Test 4: zero delta silences; zero envelope silences.
    do_reset();
    repeat (5) drive(32'h0000_0000, 9'd300, 1'b0);
    idle(4);
    chk("t4_count", 32'(q_samp.size()), 32'd5);
    errs = 0;
    foreach (q_samp[k]) if (q_samp[k] != 10'd0) errs++;
    chk("t4_zero_delta", 32'(errs), 32'd0);
    chk("t4_lfsr_held", 32'(u_bus.o_lfsr), 32'h0001);
    clear_q();
    repeat (3) drive(32'h8000_0000, 9'd0, 1'b0);
    idle(4);
    chk("t4_env0_count", 32'(q_samp.size()), 32'd3);
    errs = 0;
    foreach (q_samp[k]) if (q_samp[k] != 10'd0) errs++;
    chk("t4_env0", 32'(errs), 32'd0);
    chk("t4_env0_lfsr", 32'(u_bus.o_lfsr), 32'h4000);

    // Test 5: full long-mode period with envelope 511.
    do_reset();
    repeat (32768) drive(32'hFFFF_FFFF, 9'd511, 1'b0);
    idle(4);
    chk("t5_count", 32'(q_lfsr.size()), 32'd32768);
    errs = 0; zero_seen = 0; first_ret = 0;
    m = 15'h0001;
    for (int k = 0; k < q_lfsr.size(); k++) begin
      if (k > 0) m = model_step(m, 1'b0);
      if (q_lfsr[k] != m) errs++;
      if (q_lfsr[k] == 15'h0000) zero_seen++;
      es = m[0] ? 10'h201 : 10'h1FF;
      if (q_samp[k] != es) errs++;
      if (k > 0 && q_lfsr[k] == 15'h0001 && first_ret == 0) first_ret = k;
    end
    chk("t5_track", 32'(errs), 32'd0);
    chk("t5_never_zero", 32'(zero_seen), 32'd0);
    chk("t5_period", 32'(first_ret), 32'd32767);
    chk("t5_final", 32'(u_bus.o_lfsr), 32'h0001);

    // Test 6: accumulator wrap, then per-strobe mode toggling.
    do_reset();
    drive(32'hFFFF_FFFF, 9'd7, 1'b0);
    drive(32'h0000_0001, 9'd7, 1'b0);
    drive(32'h8000_0000, 9'd7, 1'b0);
    idle(4);
    chk("t6_wrap_count", 32'(q_lfsr.size()), 32'd3);
    if (q_lfsr.size() == 3) begin
      chk("t6_l0", 32'(q_lfsr[0]), 32'h0001);
      chk("t6_l1", 32'(q_lfsr[1]), 32'h4000);
      chk("t6_l2", 32'(q_lfsr[2]), 32'h4000);
      chk("t6_s0", 32'(q_samp[0]), 32'h3F9);
      chk("t6_s1", 32'(q_samp[1]), 32'h007);
    end
    clear_q();
    for (int i = 0; i < 16; i++) drive(32'hFFFF_FFFF, 9'd33, i[0]);
    idle(4);
    chk("t6_tog_count", 32'(q_lfsr.size()), 32'd16);
    errs = 0;
    m = 15'h4000;
    for (int k = 0; k < q_lfsr.size(); k++) begin
      m = model_step(m, k[0]);
      if (q_lfsr[k] != m) errs++;
      es = m[0] ? 10'h3DF : 10'h021;
      if (q_samp[k] != es) errs++;
    end
    chk("t6_toggle", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", r_total, r_bad);
    $finish;
  end

endmodule
